sha256_msg_schedule: RTL and testbench

Streams the 64-word SHA-256 message schedule W[0..63] for one 512-bit padded message block. It sits between the block padder, which emits 512-bit blocks from the 80-byte Bitcoin header (two blocks for the first hash, one for the second), and the compression round engine, which consumes one W word per round. Input and output use valid/ready handshakes. Words are generated with a 16-word sliding window, so no 64-entry storage is needed.

---
 rtl/sha256_msg_schedule.sv | 84 ++++++++
 tb/tb_sha256_msg_schedule.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_schedule
// Brief    : Streams SHA-256 schedule words W[0..63] for one 512-bit block
//            using a 16-word sliding window and valid/ready handshakes.
// Revision : 1.0
// ============================================================================
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         w_last
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [5:0] c_LAST_T = 6'd63;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_win [16];
  logic [5:0]  r_t;
  logic        w_accept;
  logic        w_fire;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  // Outputs depend only on registered state, so no input-to-output paths.
  assign blk_ready = (r_state == S_IDLE);
  assign w_valid   = (r_state == S_RUN);
  assign w_data    = r_win[0];
  assign w_idx     = r_t;
  assign w_last    = (r_state == S_RUN) && (r_t == c_LAST_T);

  assign w_accept  = blk_valid && blk_ready;
  assign w_fire    = w_valid && w_ready;
  assign w_new     = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (blk_valid) w_state_nxt = S_RUN;
      S_RUN:  if (w_fire && (r_t == c_LAST_T)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_t     <= 6'd0;
      for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        for (int i = 0; i < 16; i++) r_win[i] <= blk_data[511 - 32*i -: 32];
        r_t <= 6'd0;
      end else if (w_fire) begin
        for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
        r_win[15] <= w_new;
        // 6-bit counter wraps 63 -> 0 on the final handshake.
        r_t <= r_t + 6'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_schedule
// Brief    : Self-checking bench for sha256_msg_schedule against a full-array
//            SHA-256 schedule expansion model.
// Revision : 1.0
// ============================================================================
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_w [64];
  logic [31:0] obs_w [64];

  sha256_msg_schedule u_dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_idx     (w_idx),
    .w_last    (w_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Reference: expand the whole 64-entry schedule directly from the block.
  task automatic build_exp(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
      s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
      exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic accept(input logic [511:0] b, input bit keep_valid);
    build_exp(b);
    blk_data  = b;
    blk_valid = 1'b1;
    check_eq("acc_blk_ready", {31'd0, blk_ready}, 32'd1);
    check_eq("acc_w_valid", {31'd0, w_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) blk_valid = 1'b0;
  endtask

  task automatic run_words(input int mode, input int stop_at);
    int idx = 0;
    int cyc = 0;
    int stall_left = 0;
    bit did16 = 1'b0;
    bit did63 = 1'b0;
    bit rdy;
    bit vld;
    while (idx < stop_at && cyc < 1000) begin
      vld = w_valid;
      check_eq("w_valid", {31'd0, w_valid}, 32'd1);
      check_eq("w_idx", {26'd0, w_idx}, idx);
      check_eq("w_data", w_data, exp_w[idx]);
      check_eq("w_last", {31'd0, w_last}, {31'd0, idx == 63});
      obs_w[idx] = w_data;
      if (mode == 0) begin
        rdy = 1'b1;
      end else begin
        if (idx == 16 && !did16) begin stall_left = 5; did16 = 1'b1; end
        if (idx == 63 && !did63) begin stall_left = 5; did63 = 1'b1; end
        if (stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else begin
          rdy = ($urandom_range(0, 3) != 0);
        end
      end
      w_ready = rdy;
      @(posedge clk);
      @(negedge clk);
      if (rdy && vld) idx++;
      cyc++;
    end
    w_ready = 1'b0;
    if (idx < stop_at) check_eq("timeout_words", idx, stop_at);
  endtask

  task automatic end_check();
    check_eq("end_blk_ready", {31'd0, blk_ready}, 32'd1);
    check_eq("end_w_valid", {31'd0, w_valid}, 32'd0);
    check_eq("end_w_last", {31'd0, w_last}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc_blk;
    logic [511:0] blk_a;
    logic [511:0] blk_b;
    abc_blk = {32'h61626380, 448'd0, 32'h00000018};

    // Reset with a block offered: it must not be taken.
    rst       = 1'b1;
    blk_valid = 1'b1;
    blk_data  = rand_block();
    w_ready   = 1'b0;
    @(negedge clk);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_w_valid", {31'd0, w_valid}, 32'd0);
      check_eq("rst_blk_ready", {31'd0, blk_ready}, 32'd1);
    end
    rst       = 1'b0;
    blk_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_blk_ready", {31'd0, blk_ready}, 32'd1);
    check_eq("post_rst_w_valid", {31'd0, w_valid}, 32'd0);
    check_eq("post_rst_w_idx", {26'd0, w_idx}, 32'd0);
    check_eq("post_rst_w_data", w_data, 32'd0);
    check_eq("post_rst_w_last", {31'd0, w_last}, 32'd0);

    // "abc" block, full throughput.
    accept(abc_blk, 1'b0);
    run_words(0, 64);
    end_check();
    check_eq("abc_w0", obs_w[0], 32'h61626380);
    check_eq("abc_w15", obs_w[15], 32'h00000018);
    check_eq("abc_w16", obs_w[16], 32'h61626380);
    check_eq("abc_w17", obs_w[17], 32'h000f0000);
    check_eq("abc_w63", obs_w[63], 32'h12b1edeb);

    // All-zero block.
    accept(512'd0, 1'b0);
    run_words(0, 64);
    end_check();

    // "abc" block with backpressure.
    accept(abc_blk, 1'b0);
    run_words(1, 64);
    end_check();
    check_eq("bp_abc_w63", obs_w[63], 32'h12b1edeb);

    // Reset after the t=20 handshake, then zero block.
    accept(abc_blk, 1'b0);
    run_words(0, 21);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_w_valid", {31'd0, w_valid}, 32'd0);
    check_eq("midrst_blk_ready", {31'd0, blk_ready}, 32'd1);
    check_eq("midrst_w_idx", {26'd0, w_idx}, 32'd0);
    rst = 1'b0;
    accept(512'd0, 1'b0);
    run_words(0, 64);
    end_check();

    // Back-to-back blocks with blk_valid held high; blk_data changes in RUN.
    blk_a = rand_block();
    blk_b = rand_block();
    accept(blk_a, 1'b1);
    blk_data = blk_b;
    run_words(0, 64);
    end_check();
    accept(blk_b, 1'b0);
    run_words(1, 64);
    end_check();

    // A couple of random blocks under random backpressure.
    repeat (2) begin
      accept(rand_block(), 1'b0);
      run_words(1, 64);
      end_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
